instr_mem_sync: RTL and testbench

//  Parametrised synchronous instruction memory for the MIPS fetch stage.
//  - Replaces the fixed combinational ROM with a registered-read RAM.
//  - Handshaked fetch: one request in, one result out 1 cycle later.
//  - Has a program-load port, stall hold, and address/alignment fault detection.
//  - Sits between the PC register and the IF/ID pipeline register.

---
 rtl/instr_mem_sync_if.sv | 30 +++
 rtl/instr_mem_sync.sv | 113 +++++++++++
 tb/tb_instr_mem_sync.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_sync_if.sv
// Fetch/load bus between the PC/loader side (master) and the instruction memory (slave).
interface instr_mem_sync_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              fetch_req;
    logic [ADDR_W-1:0] pc;
    logic              stall;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fetch_err;
    logic              load_en;
    logic [IDX_W-1:0]  load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              busy;

    modport master (
        output fetch_req, pc, stall, load_en, load_addr, load_data, load_last,
        input  instr, instr_valid, fetch_err, busy
    );

    modport slave (
        input  fetch_req, pc, stall, load_en, load_addr, load_data, load_last,
        output instr, instr_valid, fetch_err, busy
    );
endinterface

// File: rtl/instr_mem_sync.sv
// Registered-read instruction memory for the fetch stage with program-load port and fault flags.
// Optional per-word even parity when INSTR_MEM_PARITY_EN is defined.
module instr_mem_sync #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 64,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       ADDR_LSB = 2,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    instr_mem_sync_if.slave   bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned LA_EXT_W = IDX_W + 1;
`ifdef INSTR_MEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ADDR_LSB) - 64'd1);

    typedef enum logic {RUN, LOAD} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [MEM_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] pc_idx;
    logic              misaligned;
    logic              out_of_range;
    logic [MEM_W-1:0]  rd_word;
    logic              parity_bad;
    logic              fetch_ok;
    logic              wr_en;
    logic [MEM_W-1:0]  wr_word;

    // Index is kept at full PC width so large PCs fault instead of aliasing.
    assign pc_idx       = bus.pc >> ADDR_LSB;
    assign misaligned   = (bus.pc & ALIGN_MASK) != '0;
    assign out_of_range = pc_idx >= ADDR_W'(DEPTH);
    assign rd_word      = mem[pc_idx[IDX_W-1:0]];
    assign fetch_ok     = (state_q == RUN) && !bus.load_en && bus.fetch_req;
    assign wr_en        = !rst && bus.load_en && ({1'b0, bus.load_addr} < LA_EXT_W'(DEPTH));

`ifdef INSTR_MEM_PARITY_EN
    assign wr_word    = {^bus.load_data, bus.load_data};
    assign parity_bad = ^rd_word;
`else
    assign wr_word    = bus.load_data;
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q <= RUN;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            RUN:     if (bus.load_en && !bus.load_last) state_d = LOAD;
            LOAD:    if (bus.load_en &&  bus.load_last) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Stall freezes the result registers; otherwise they track this cycle's accepted fetch.
    always_comb begin : output_next
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        busy_d  = (state_d == LOAD);
        if (!bus.stall) begin
            valid_d = fetch_ok;
            instr_d = NOP_WORD;
            err_d   = 1'b0;
            if (fetch_ok) begin
                if (misaligned || out_of_range || parity_bad) begin
                    err_d = 1'b1;
                end else begin
                    instr_d = rd_word[DATA_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin : mem_write
        if (wr_en) begin
            mem[bus.load_addr] <= wr_word;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_err   = err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: expected results are queued per driven cycle and checked after the edge.
module tb_instr_mem_sync;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 32;

    typedef struct packed {
        logic        busy;
        logic        valid;
        logic        err;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    instr_mem_sync_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    instr_mem_sync #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ADDR_LSB(2), .NOP_WORD(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    string       phase = "reset";

    // Reference state kept by the bench
    logic [31:0] ref_mem [DEPTH];
    logic        corrupt [DEPTH];
    logic        m_load  = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_instr = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", phase, tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fr, input logic [31:0] p, input logic st,
                         input logic le, input logic [5:0] la, input logic [31:0] ld,
                         input logic ll);
        exp_t        e;
        logic [31:0] idx;
        logic        bad;
        logic        ok;
        rst           = r;
        bus.fetch_req = fr;
        bus.pc        = p;
        bus.stall     = st;
        bus.load_en   = le;
        bus.load_addr = la;
        bus.load_data = ld;
        bus.load_last = ll;

        if (r) begin
            m_load = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_instr = 32'h0;
        end else begin
            ok = !m_load && !le && fr;
            if (!st) begin
                m_valid = ok;
                m_err   = 1'b0;
                m_instr = 32'h0;
                if (ok) begin
                    idx = p >> 2;
                    bad = (p[1:0] != 2'b00) || (idx >= 32'(DEPTH));
                    if (!bad) bad = corrupt[idx[5:0]];
                    if (bad) m_err = 1'b1;
                    else     m_instr = ref_mem[idx[5:0]];
                end
            end
            if (le) begin
                ref_mem[la] = ld;
                corrupt[la] = 1'b0;
                m_load      = !ll;
            end
        end
        e.busy = m_load; e.valid = m_valid; e.err = m_err; e.instr = m_instr;
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("busy",  32'(bus.busy),        32'(e.busy));
            check("valid", 32'(bus.instr_valid), 32'(e.valid));
            check("err",   32'(bus.fetch_err),   32'(e.err));
            check("instr", bus.instr,            e.instr);
        end
    endtask

    task automatic fetch(input logic [31:0] p);
        drive(1'b0, 1'b1, p, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d, input logic last, input logic fr);
        drive(1'b0, fr, {24'h0, a, 2'b00}, 1'b0, 1'b1, a, d, last);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i] = 32'h0;
            corrupt[i] = 1'b0;
        end

        phase = "reset";
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0);

        phase = "load4";
        load(6'd0, 32'h20080020, 1'b0, 1'b0);
        load(6'd1, 32'h20090037, 1'b0, 1'b0);
        load(6'd2, 32'h01098024, 1'b0, 1'b0);
        load(6'd3, 32'h01098025, 1'b1, 1'b0);
        phase = "b2b";
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hC);
        idle();

        phase = "fault";
        fetch(32'h6);
        fetch(32'h100);
        fetch(32'h400);
        fetch(32'h101);
        fetch(32'hFC);
        idle();

        phase = "stall";
        fetch(32'h4);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0);
        idle();
        fetch(32'h6);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0);
        idle();

        phase = "ldvsfetch";
        load(6'd4, 32'hAAAA0004, 1'b1, 1'b1);
        load(6'd6, 32'hAAAA0006, 1'b0, 1'b1);
        fetch(32'h18);
        load(6'd5, 32'hAAAA0005, 1'b0, 1'b1);
        load(6'd7, 32'hAAAA0007, 1'b1, 1'b1);
        fetch(32'h10);
        fetch(32'h14);
        fetch(32'h18);
        fetch(32'h1C);

        phase = "rstmid";
        load(6'd0, 32'h11110000, 1'b0, 1'b0);
        load(6'd1, 32'h11110001, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
        fetch(32'h0);
        fetch(32'h4);
        idle();

        phase = "random";
        for (int i = 0; i < 40; i++) begin
            logic [31:0] p;
            p = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 7) == 0) p = p | 32'h2;
            drive(1'b0, 1'($urandom_range(0, 1)), p, ($urandom_range(0, 3) == 0),
                  1'b0, 6'd0, 32'h0, 1'b0);
        end
        idle();

`ifdef INSTR_MEM_PARITY_EN
        phase = "parity";
        dut.mem[1] = dut.mem[1] ^ {1'b1, 32'h0};
        corrupt[1] = 1'b1;
        fetch(32'h4);
        fetch(32'h0);
        load(6'd1, 32'h22220001, 1'b1, 1'b0);
        fetch(32'h4);
        idle();
`endif

        if (sb.size() != 0) check("sb_left", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
